// File: rtl/fft_ctrl.sv
// fft_ctrl: sequences load, column pass, row pass and transposed dump for the 64-point base-8 FFT memory.
module fft_ctrl #(
    parameter int DATA_WD = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 in_vld_i,
    input  logic [DATA_WD-1:0]   in_dat_i,
    output logic                 out_vld_o,
    output logic [DATA_WD-1:0]   out_dat_o,
    output logic                 dim_sel_o,
    output logic [2:0]           rd_addr_1x8_o,
    output logic                 rd_vld_1x8_o,
    input  logic                 rd_vld_1x8_i,
    input  logic [8*DATA_WD-1:0] rd_dat_1x8_i,
    output logic [2:0]           wr_addr_1x8_o,
    output logic                 wr_vld_1x8_o,
    output logic [8*DATA_WD-1:0] wr_dat_1x8_o,
    output logic [5:0]           rd_addr_1x1_o,
    output logic                 rd_vld_1x1_o,
    input  logic                 rd_vld_1x1_i,
    input  logic [DATA_WD-1:0]   rd_dat_1x1_i,
    output logic [5:0]           wr_addr_1x1_o,
    output logic                 wr_vld_1x1_o,
    output logic [DATA_WD-1:0]   wr_dat_1x1_o,
    output logic                 core_vld_o,
    output logic [8*DATA_WD-1:0] core_dat_o,
    output logic [2:0]           core_idx_o,
    output logic                 core_pass_o,
    input  logic                 core_vld_i,
    input  logic [8*DATA_WD-1:0] core_dat_i
);
    typedef enum logic [2:0] {IDLE, LOAD, COL, ROW, DUMP} state_t;
    state_t state_q, state_d;
    logic [6:0] cnt_q, cnt_d, ret_q, ret_d;
    logic [3:0] res_q, res_d;
    logic pend_q, pend_d;
    logic core_vld_q, core_vld_d, core_pass_q, core_pass_d;
    logic [2:0] core_idx_q, core_idx_d, wr_addr_q, wr_addr_d;
    logic [8*DATA_WD-1:0] core_dat_q, core_dat_d, wr_dat_q, wr_dat_d;
    logic wr_vld_q, wr_vld_d, out_vld_q, out_vld_d;
    logic [DATA_WD-1:0] out_dat_q, out_dat_d;
    logic pass, ret8, ret1, acc_core, last_wr;
    // cnt counts load writes, vector reads or dump reads; ret counts accepted read returns
    always_comb begin
        pass         = state_q == COL || state_q == ROW;
        rd_vld_1x8_o = pass && !cnt_q[3];
        rd_vld_1x1_o = state_q == DUMP && !cnt_q[6];
        wr_vld_1x1_o = state_q == LOAD && in_vld_i;
        ret8         = pass && pend_q && rd_vld_1x8_i;
        ret1         = state_q == DUMP && pend_q && rd_vld_1x1_i;
        acc_core     = pass && core_vld_i && !res_q[3];
        last_wr      = pass && wr_vld_q && wr_addr_q == 3'd7;
        done_o       = state_q == DUMP && out_vld_q && ret_q == 7'd64;
        pend_d       = rd_vld_1x8_o || rd_vld_1x1_o;
        core_vld_d   = ret8;
        core_dat_d   = ret8 ? rd_dat_1x8_i : '0;
        core_idx_d   = ret8 ? ret_q[2:0] : '0;
        core_pass_d  = ret8 && state_q == ROW;
        wr_vld_d     = acc_core;
        wr_addr_d    = acc_core ? res_q[2:0] : '0;
        wr_dat_d     = acc_core ? core_dat_i : '0;
        out_vld_d    = ret1;
        out_dat_d    = ret1 ? rd_dat_1x1_i : '0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        ret_d        = ret_q;
        res_d        = res_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = LOAD;
                cnt_d   = '0;
                ret_d   = '0;
                res_d   = '0;
            end
            LOAD: begin
                cnt_d = cnt_q + 7'(in_vld_i);
                if (in_vld_i && cnt_q == 7'd63) begin
                    state_d = COL;
                    cnt_d   = '0;
                end
            end
            COL, ROW: begin
                cnt_d = cnt_q + 7'(rd_vld_1x8_o);
                ret_d = ret_q + 7'(ret8);
                res_d = res_q + 4'(acc_core);
                if (last_wr) begin
                    state_d = state_q == COL ? ROW : DUMP;
                    cnt_d   = '0;
                    ret_d   = '0;
                    res_d   = '0;
                end
            end
            DUMP: begin
                cnt_d = cnt_q + 7'(rd_vld_1x1_o);
                ret_d = ret_q + 7'(ret1);
                if (done_o) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ret_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ret_q       <= '0;
            res_q       <= '0;
            pend_q      <= 1'b0;
            core_vld_q  <= 1'b0;
            core_dat_q  <= '0;
            core_idx_q  <= '0;
            core_pass_q <= 1'b0;
            wr_vld_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_dat_q    <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ret_q       <= ret_d;
            res_q       <= res_d;
            pend_q      <= pend_d;
            core_vld_q  <= core_vld_d;
            core_dat_q  <= core_dat_d;
            core_idx_q  <= core_idx_d;
            core_pass_q <= core_pass_d;
            wr_vld_q    <= wr_vld_d;
            wr_addr_q   <= wr_addr_d;
            wr_dat_q    <= wr_dat_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
        end
    end
    assign busy_o        = state_q != IDLE;
    assign dim_sel_o     = state_q == COL;
    assign rd_addr_1x8_o = cnt_q[2:0];
    assign rd_addr_1x1_o = rd_vld_1x1_o ? {cnt_q[2:0], cnt_q[5:3]} : '0;
    assign wr_addr_1x1_o = wr_vld_1x1_o ? cnt_q[5:0] : '0;
    assign wr_dat_1x1_o  = wr_vld_1x1_o ? in_dat_i : '0;
    assign core_vld_o    = core_vld_q;
    assign core_dat_o    = core_dat_q;
    assign core_idx_o    = core_idx_q;
    assign core_pass_o   = core_pass_q;
    assign wr_vld_1x8_o  = wr_vld_q;
    assign wr_addr_1x8_o = wr_addr_q;
    assign wr_dat_1x8_o  = wr_dat_q;
    assign out_vld_o     = out_vld_q;
    assign out_dat_o     = out_dat_q;
endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: directed bench with an 8x8 memory model and an in-order butterfly core model.
module tb_fft_ctrl;
    localparam int W = 10;
    logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, in_vld_i = 1'b0, spur = 1'b0;
    logic [W-1:0] in_dat_i = '0;
    logic busy_o, done_o, out_vld_o, dim_sel_o, rd_vld_1x8_o, wr_vld_1x8_o, rd_vld_1x1_o, wr_vld_1x1_o;
    logic core_vld_o, core_pass_o, core_vld_i, core_m;
    logic [W-1:0] out_dat_o, wr_dat_1x1_o, rd_dat_1x1_i;
    logic [2:0] rd_addr_1x8_o, wr_addr_1x8_o, core_idx_o;
    logic [5:0] rd_addr_1x1_o, wr_addr_1x1_o;
    logic [8*W-1:0] rd_dat_1x8_i, wr_dat_1x8_o, core_dat_o, core_dat_i;
    logic rd_vld_1x8_i, rd_vld_1x1_i;
    int checks = 0, errors = 0, cyc = 0, run_id = 0, seen_id = 0;
    logic var_lat = 1'b0;
    logic [W-1:0] cadd = '0;

    assign core_vld_i = core_m | spur;

    fft_ctrl #(.DATA_WD(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .in_vld_i(in_vld_i), .in_dat_i(in_dat_i), .out_vld_o(out_vld_o), .out_dat_o(out_dat_o),
        .dim_sel_o(dim_sel_o), .rd_addr_1x8_o(rd_addr_1x8_o), .rd_vld_1x8_o(rd_vld_1x8_o),
        .rd_vld_1x8_i(rd_vld_1x8_i), .rd_dat_1x8_i(rd_dat_1x8_i), .wr_addr_1x8_o(wr_addr_1x8_o),
        .wr_vld_1x8_o(wr_vld_1x8_o), .wr_dat_1x8_o(wr_dat_1x8_o), .rd_addr_1x1_o(rd_addr_1x1_o),
        .rd_vld_1x1_o(rd_vld_1x1_o), .rd_vld_1x1_i(rd_vld_1x1_i), .rd_dat_1x1_i(rd_dat_1x1_i),
        .wr_addr_1x1_o(wr_addr_1x1_o), .wr_vld_1x1_o(wr_vld_1x1_o), .wr_dat_1x1_o(wr_dat_1x1_o),
        .core_vld_o(core_vld_o), .core_dat_o(core_dat_o), .core_idx_o(core_idx_o),
        .core_pass_o(core_pass_o), .core_vld_i(core_vld_i), .core_dat_i(core_dat_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // row vector r holds words r*8..r*8+7; column vector c holds words c, c+8, ...
    function automatic int mi(input logic col, input logic [2:0] a, input int j);
        return col ? j * 8 + int'(a) : int'(a) * 8 + j;
    endfunction

    logic [W-1:0] mem [64];
    always @(posedge clk) begin
        rd_vld_1x8_i <= !rst && rd_vld_1x8_o;
        rd_vld_1x1_i <= !rst && rd_vld_1x1_o;
        for (int j = 0; j < 8; j++) rd_dat_1x8_i[j*W +: W] <= mem[mi(dim_sel_o, rd_addr_1x8_o, j)];
        rd_dat_1x1_i <= mem[rd_addr_1x1_o];
        if (wr_vld_1x8_o)
            for (int j = 0; j < 8; j++) mem[mi(dim_sel_o, wr_addr_1x8_o, j)] = wr_dat_1x8_o[j*W +: W];
        if (wr_vld_1x1_o) mem[wr_addr_1x1_o] = wr_dat_1x1_o;
    end

    logic [8*W-1:0] qd [$];
    int qt [$];
    int last_due = 0;
    int lat_tab [8] = '{3, 1, 5, 2, 4, 1, 5, 3};
    always @(posedge clk) begin
        int d;
        logic [8*W-1:0] v;
        core_m <= 1'b0;
        if (rst) begin
            qd.delete();
            qt.delete();
            last_due = 0;
        end else begin
            if (core_vld_o) begin
                d = cyc + (var_lat ? lat_tab[core_idx_o] : 1);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                for (int j = 0; j < 8; j++) v[j*W +: W] = core_dat_o[j*W +: W] + cadd;
                qd.push_back(v);
                qt.push_back(d);
            end
            if (qt.size() > 0 && qt[0] <= cyc + 1) begin
                core_m    <= 1'b1;
                core_dat_i <= qd.pop_front();
                void'(qt.pop_front());
            end
        end
    end

    int rd_n, cv_n, wr_n, prot_err, done_n;
    logic [W-1:0] outs [$];
    always @(negedge clk) begin
        if (seen_id != run_id) begin
            seen_id = run_id;
            rd_n = 0; cv_n = 0; wr_n = 0; prot_err = 0; done_n = 0;
            outs.delete();
        end
        if ((wr_vld_1x1_o || rd_vld_1x1_o) && (wr_vld_1x8_o || rd_vld_1x8_o)) prot_err++;
        if (rd_vld_1x8_o) begin
            if (dim_sel_o != (rd_n < 8)) prot_err++;
            rd_n++;
        end
        if (core_vld_o) begin
            if (int'(core_idx_o) != cv_n % 8 || core_pass_o != (cv_n >= 8)) prot_err++;
            cv_n++;
        end
        if (wr_vld_1x8_o) begin
            if (int'(wr_addr_1x8_o) != wr_n % 8 || dim_sel_o != (wr_n < 8)) prot_err++;
            wr_n++;
        end
        if (out_vld_o) outs.push_back(out_dat_o);
        if (done_o) done_n++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({busy_o, done_o, out_vld_o, dim_sel_o, rd_vld_1x8_o, wr_vld_1x8_o, rd_vld_1x1_o,
                     wr_vld_1x1_o, core_vld_o, core_pass_o, |core_idx_o, |wr_addr_1x8_o, |rd_addr_1x8_o,
                     |rd_addr_1x1_o, |wr_addr_1x1_o, |wr_dat_1x1_o, |out_dat_o, |core_dat_o, |wr_dat_1x8_o});
    endfunction

    task automatic start_run(input string tag);
        @(negedge clk) run_id++;
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        check({tag, "_busy_start"}, int'(busy_o), 1);
    endtask

    task automatic load(input bit gaps, input bit spurs);
        for (int n = 0; n < 64; n++) begin
            if (gaps && n % 5 == 2) begin
                @(negedge clk);
                in_vld_i = 1'b0;
                spur = spurs;
            end
            @(negedge clk);
            in_vld_i = 1'b1;
            in_dat_i = W'(n);
            spur = spurs && n % 9 == 4;
        end
        @(negedge clk);
        in_vld_i = 1'b0;
        spur = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int add);
        int t = 0;
        while (done_n == 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check({tag, "_done_seen"}, int'(done_n > 0), 1);
        repeat (5) @(negedge clk);
        check({tag, "_done_cnt"}, done_n, 1);
        check({tag, "_busy_end"}, int'(busy_o), 0);
        check({tag, "_nout"}, outs.size(), 64);
        check({tag, "_protocol"}, prot_err, 0);
        check({tag, "_nrd"}, rd_n, 16);
        check({tag, "_ncore"}, cv_n, 16);
        check({tag, "_nwr"}, wr_n, 16);
        for (int k = 0; k < 64; k++)
            check($sformatf("%s_out%0d", tag, k), k < outs.size() ? int'(outs[k]) : -1,
                  (k % 8) * 8 + k / 8 + 2 * add);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", all_outs(), 0);

        start_run("ident");
        load(1'b0, 1'b0);
        finish_run("ident", 0);

        cadd = W'(1);
        start_run("add1");
        load(1'b0, 1'b0);
        finish_run("add1", 1);

        cadd = '0;
        var_lat = 1'b1;
        start_run("varlat");
        load(1'b1, 1'b0);
        finish_run("varlat", 0);

        var_lat = 1'b0;
        @(negedge clk) in_vld_i = 1'b1;
        in_dat_i = W'(999);
        @(negedge clk) in_vld_i = 1'b0;
        check("idle_invld_ignored", int'(busy_o), 0);
        start_run("ignore");
        load(1'b0, 1'b1);
        t = 0;
        while (!dim_sel_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("ignore_col_seen", int'(dim_sel_o), 1);
        start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        finish_run("ignore", 0);

        start_run("abort");
        load(1'b0, 1'b0);
        t = 0;
        while (!(core_vld_o && core_pass_o) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("abort_row_seen", int'(core_vld_o && core_pass_o), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outs", all_outs(), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle", all_outs(), 0);

        start_run("fresh");
        load(1'b0, 1'b0);
        finish_run("fresh", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
